uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin scheduler that shares one `uart_tx` transmitter among `NUM_REQ` byte requesters. Each requester offers a byte with a valid/ready handshake. The block grants one requester, holds the byte and `start` on the transmitter until it reports `busy`, then waits for the frame to finish before arbitrating again. It sits between the host-side byte sources and the single `uart_tx` instance, and adds a start-acknowledge timeout.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, payload width per requester (≤10; zero-extended onto `tx_data`)
- `ID_W`, 2, width of `grant_id`; must satisfy 2^`ID_W` ≥ `NUM_REQ`
- `START_TIMEOUT`, 64, clk cycles to wait in LAUNCH for `tx_busy` to rise

Ports:
- `clk` input 1: single clock, same clock as `uart_tx`
- `reset` input 1: asynchronous, active-low reset
- `req_valid` input `NUM_REQ`: requester i has a byte pending
- `req_data` input `NUM_REQ*DATA_W`: byte of requester i at `[i*DATA_W +: DATA_W]`
- `req_ready` output `NUM_REQ`: one-hot accept pulse to the granted requester
- `tx_data` output 10: to `uart_tx.in`
- `tx_start` output 1: to `uart_tx.start`
- `tx_busy` input 1: from `uart_tx.busy`
- `grant_id` output `ID_W`: index of the current or last granted requester
- `sched_busy` output 1: high in every state except IDLE
- `err_timeout` output 1: one-cycle pulse when LAUNCH times out

## Operation
- **States:**
  - IDLE: if `|req_valid`, go to GRANT and register the winner into `grant_id`.
  - GRANT: lasts 1 cycle. Set `req_ready[grant_id]`=1. Capture `req_data` slice into `tx_data` as `{zero-pad, byte}`. Set `ptr` to `(grant_id+1) mod NUM_REQ`. Go to LAUNCH.
  - LAUNCH: `tx_start`=1 and `tx_data` held.
    - If `tx_busy`=1, clear `tx_start` and go to DRAIN.
    - Otherwise, if `tmo_cnt`==`START_TIMEOUT`-1, pulse `err_timeout`, clear `tx_start` and go to IDLE (byte dropped).
  - DRAIN: wait for `tx_busy`=0, then go to IDLE.
- **Arbitration:**
  - Round-robin, searching upward from `ptr` with wrap. The first asserted `req_valid` wins.
  - `ptr` resets to 0 and advances only in GRANT.
- **Requester rule:** `req_valid` and `req_data` stay stable from assertion until `req_ready` is sampled high. Transfer occurs on the cycle `req_valid & req_ready`.
- **Transmitter contract:** `tx_start` is held rather than pulsed because `uart_tx` samples `start` and `in` only on its baud tick. `tx_data` stays constant from GRANT until DRAIN exit.
- **`tmo_cnt` counter:** clears on LAUNCH entry, increments each LAUNCH cycle, and saturates at `START_TIMEOUT`-1.

## Timing
- **Reset values:** `req_ready`=0, `tx_data`=0, `tx_start`=0, `grant_id`=0, `sched_busy`=0, `err_timeout`=0, state=IDLE, `ptr`=0, `tmo_cnt`=0.
- **Asserted reset mid-operation:** forces all of the above at once. Any in-flight byte is abandoned; the `uart_tx` frame is handled by its own reset.
- **Latency:** `req_valid` seen in IDLE at cycle t gives `req_ready` high at t+1 and `tx_start` high at t+2.
- **Minimum gap between grants:** one cycle in IDLE after DRAIN exit.
- **`tx_busy`=1 on LAUNCH entry:** accepted immediately; LAUNCH is left after 1 cycle.
- **`tx_busy` rising on the timeout cycle:** success wins; no `err_timeout`.
- **Single requester:** re-granted every frame.
- **All requesters valid:** grants rotate 0,1,2,3,0…
- **Requests arriving during LAUNCH/DRAIN:** wait; none is lost.
- **All outputs are registered;** no combinational path from `req_valid` to `req_ready`.

## Structure
- **Shared package `uart_pkg`:** state encoding (IDLE/GRANT/LAUNCH/DRAIN) and the `uart_tx` frame width (10).
- **Sub-module `rr_arbiter`:** parameterised `NUM_REQ`. Takes `req` and `ptr`; outputs `gnt_id` and `gnt_any`. Purely combinational priority rotate.
- **Top level:** FSM, data hold register, `tmo_cnt` counter and `ptr`.

## Test plan
1. **Single request:** reset, then `req_valid`=4'b0001 with data 0xA5. Expect `req_ready[0]` 1-cycle pulse, `tx_data`=10'h0A5, `tx_start` held until `tx_busy` (real `uart_tx`, div=10). Serial line shows 0xA5 LSB-first with parity 0.
2. **All four valid:** `req_valid`=4'b1111 with bytes 0x11/0x22/0x33/0x44. Expect grants in order 0,1,2,3, four frames in that order, exactly one `req_ready` pulse per requester.
3. **Pointer rotation:** after requester 2 is granted, assert `req_valid`=4'b0101. Expect the next grant to be 0 (wrap from `ptr`=3), then 2.
4. **Timeout:** `tx_busy` tied 0, one request. Expect `err_timeout` pulse exactly 64 cycles after LAUNCH entry, return to IDLE, `sched_busy`=0.
5. **Reset mid-frame:** assert `reset` low during DRAIN. Expect all outputs at reset values in the same cycle; after release with 4'b0010 pending, the first grant is 1 and `ptr` starts from 0.
6. **Late `tx_busy`:** `tx_busy` rises on cycle `START_TIMEOUT`-1 of LAUNCH. Expect no `err_timeout` and a transition to DRAIN.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx scheduler: FSM state encoding and the
// width of the transmitter's parallel input.
package uart_pkg;

    localparam int FRAME_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_DRAIN  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or above
// ptr (wrapping at NUM_REQ) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_any
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        logic [ID_W:0] idxSum;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idxSum  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idxSum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (idxSum >= (ID_W + 1)'(NUM_REQ)) begin
                idxSum = idxSum - (ID_W + 1)'(NUM_REQ);
            end
            if (req[idxSum[ID_W-1:0]]) begin
                gnt_id  = idxSum[ID_W-1:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx among NUM_REQ byte sources: round-robin grant, held
// start until the transmitter goes busy, drain, and a start-ack timeout.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int ID_W          = 2,
    parameter int START_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [FRAME_W-1:0]        tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      sched_busy,
    output logic                      err_timeout
);

    localparam int              TMO_W    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    sched_state_e         state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      grantId_q, grantId_d;
    logic [NUM_REQ-1:0]   reqReady_q, reqReady_d;
    logic [FRAME_W-1:0]   txData_q, txData_d;
    logic                 txStart_q, txStart_d;
    logic                 schedBusy_q, schedBusy_d;
    logic                 errTimeout_q, errTimeout_d;
    logic [TMO_W-1:0]     tmoCnt_q, tmoCnt_d;
    logic [ID_W-1:0]      arbId;
    logic                 arbAny;
    logic [DATA_W-1:0]    grantByte;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) uArbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_id  (arbId),
        .gnt_any (arbAny)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            grantId_q    <= '0;
            reqReady_q   <= '0;
            txData_q     <= '0;
            txStart_q    <= 1'b0;
            schedBusy_q  <= 1'b0;
            errTimeout_q <= 1'b0;
            tmoCnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grantId_q    <= grantId_d;
            reqReady_q   <= reqReady_d;
            txData_q     <= txData_d;
            txStart_q    <= txStart_d;
            schedBusy_q  <= schedBusy_d;
            errTimeout_q <= errTimeout_d;
            tmoCnt_q     <= tmoCnt_d;
        end
    end

    // A busy acknowledge on the final LAUNCH cycle takes priority over timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arbAny) state_d = ST_GRANT;
            ST_GRANT:  state_d = ST_LAUNCH;
            ST_LAUNCH: begin
                if (tx_busy) begin
                    state_d = ST_DRAIN;
                end else if (tmoCnt_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN:  if (!tx_busy) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so every port is a flop.
    always_comb begin
        grantByte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantId_q == ID_W'(i)) grantByte = req_data[i*DATA_W +: DATA_W];
        end

        grantId_d = (state_q == ST_IDLE && arbAny) ? arbId : grantId_q;

        ptr_d = ptr_q;
        if (state_q == ST_GRANT) ptr_d = (grantId_q == LAST_ID) ? '0 : grantId_q + 1'b1;

        txData_d = txData_q;
        if (state_q == ST_GRANT) begin
            txData_d                = '0;
            txData_d[DATA_W-1:0]    = grantByte;
        end

        reqReady_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqReady_d[i] = (state_d == ST_GRANT) && (grantId_d == ID_W'(i));
        end

        tmoCnt_d = '0;
        if (state_q == ST_LAUNCH) tmoCnt_d = (tmoCnt_q == TMO_LAST) ? tmoCnt_q : tmoCnt_q + 1'b1;

        txStart_d    = (state_d == ST_LAUNCH);
        schedBusy_d  = (state_d != ST_IDLE);
        errTimeout_d = (state_q == ST_LAUNCH) && !tx_busy && (tmoCnt_q == TMO_LAST);
    end

    assign req_ready   = reqReady_q;
    assign tx_data     = txData_q;
    assign tx_start    = txStart_q;
    assign grant_id    = grantId_q;
    assign sched_busy  = schedBusy_q;
    assign err_timeout = errTimeout_q;

endmodule
